// File: rtl/updown_flex_counter_if.sv
// Control and status bundle for updown_flex_counter.
// The master drives the controls and reads the status; the counter is the slave.
interface updown_flex_counter_if #(
   parameter int unsigned NUM_BITS = 8
);
   logic                clear;
   logic                count_enable;
   logic                dir;
   logic                load;
   logic [NUM_BITS-1:0] load_val;
   logic [NUM_BITS-1:0] rollover_val;
   logic [1:0]          mode;
   logic [NUM_BITS-1:0] count_out;
   logic                rollover_flag;
   logic                bottom_flag;
   logic                done;

   modport master (
      output clear, count_enable, dir, load, load_val, rollover_val, mode,
      input  count_out, rollover_flag, bottom_flag, done
   );

   modport slave (
      input  clear, count_enable, dir, load, load_val, rollover_val, mode,
      output count_out, rollover_flag, bottom_flag, done
   );
endinterface

// File: rtl/updown_flex_counter.sv
// Up/down counter over the range 1..rollover_val with parallel load and
// wrap / saturate / one-shot terminal behaviour. All outputs are registered.
module updown_flex_counter #(
   parameter int unsigned NUM_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   updown_flex_counter_if.slave  bus
);

   typedef enum logic [0:0] {StRun, StDone} state_e;

   localparam logic [NUM_BITS-1:0] One = NUM_BITS'(1);

   state_e              state_q, state_d;
   logic [NUM_BITS-1:0] count_q, count_d;
   logic                roll_q, roll_d;
   logic                bot_q, bot_d;
   logic                done_q, done_d;

   logic                is_wrap;
   logic                is_oneshot;
   logic [NUM_BITS-1:0] step_val;
   logic [NUM_BITS-1:0] terminal;

   assign is_wrap    = (bus.mode == 2'd0) || (bus.mode == 2'd3);
   assign is_oneshot = (bus.mode == 2'd2);
   assign terminal   = bus.dir ? bus.rollover_val : One;

   // Candidate value for a single step; one-shot steps like saturate.
   always_comb begin
      step_val = bus.count_out;
      if (bus.dir) begin
         if (count_q >= bus.rollover_val) begin
            step_val = is_wrap ? One : count_q;
         end else begin
            step_val = count_q + One;
         end
      end else begin
         if (count_q <= One) begin
            if (is_wrap) begin
               step_val = bus.rollover_val;
            end else begin
               step_val = (count_q == '0) ? One : count_q;
            end
         end else begin
            step_val = count_q - One;
         end
      end
   end

   // Next-state: clear > load > step; flags follow the written count only.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      roll_d  = roll_q;
      bot_d   = bot_q;
      done_d  = done_q;
      if (bus.clear) begin
         state_d = StRun;
         count_d = '0;
         roll_d  = 1'b0;
         bot_d   = 1'b0;
         done_d  = 1'b0;
      end else if (bus.load) begin
         state_d = StRun;
         count_d = bus.load_val;
         roll_d  = (bus.load_val == bus.rollover_val);
         bot_d   = (bus.load_val == One);
         done_d  = 1'b0;
      end else if (bus.count_enable && (bus.rollover_val != '0) && (state_q == StRun)) begin
         count_d = step_val;
         roll_d  = (step_val == bus.rollover_val);
         bot_d   = (step_val == One);
         // One-shot latches once the step lands on the terminal value.
         if (is_oneshot && (step_val == terminal)) begin
            state_d = StDone;
            done_d  = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         count_q <= '0;
         roll_q  <= 1'b0;
         bot_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         roll_q  <= roll_d;
         bot_q   <= bot_d;
         done_q  <= done_d;
      end
   end

   assign bus.count_out     = count_q;
   assign bus.rollover_flag = roll_q;
   assign bus.bottom_flag   = bot_q;
   assign bus.done          = done_q;

endmodule

// File: tb/tb_updown_flex_counter.sv
// Directed vector bench for updown_flex_counter (8-bit and 4-bit instances).
module tb_updown_flex_counter;

   typedef struct {
      int         reps;
      logic       rst, clr, ld, en, dir;
      logic [1:0] mode;
      logic [7:0] lv, rv, ecnt;
      logic       eroll, ebot, edone;
   } vec_t;

   logic tb_clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];

   always #5 tb_clk = ~tb_clk;

   updown_flex_counter_if #(.NUM_BITS(8)) ifc ();
   updown_flex_counter_if #(.NUM_BITS(4)) ifc4 ();

   updown_flex_counter #(.NUM_BITS(8)) dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   updown_flex_counter #(.NUM_BITS(4)) dut4 (
      .clk (tb_clk),
      .rst (rst),
      .bus (ifc4.slave)
   );

   task automatic add(input int reps, input logic r, input logic c, input logic l,
                      input logic e, input logic d, input logic [1:0] m,
                      input logic [7:0] lv, input logic [7:0] rv, input logic [7:0] ec,
                      input logic er, input logic eb, input logic ed);
      vec_t v;
      v.reps = reps; v.rst = r; v.clr = c; v.ld = l; v.en = e; v.dir = d; v.mode = m;
      v.lv = lv; v.rv = rv; v.ecnt = ec; v.eroll = er; v.ebot = eb; v.edone = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] cnt, input logic r,
                        input logic b, input logic d, input logic [7:0] ecnt,
                        input logic er, input logic eb, input logic ed);
      n_checks++;
      if ({cnt, r, b, d} === {ecnt, er, eb, ed}) begin
         n_pass++;
      end else begin
         $display("FAIL %s: count/roll/bot/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
                  name, cnt, r, b, d, ecnt, er, eb, ed);
      end
   endtask

   initial begin
      rst = 1'b1;
      ifc.clear = 0; ifc.count_enable = 0; ifc.dir = 1; ifc.load = 0;
      ifc.load_val = 0; ifc.rollover_val = 0; ifc.mode = 0;
      ifc4.clear = 0; ifc4.count_enable = 0; ifc4.dir = 1; ifc4.load = 0;
      ifc4.load_val = 0; ifc4.rollover_val = 0; ifc4.mode = 0;

      //   reps rst clr ld en dir mode lv   rv  cnt roll bot done
      // Reset and legacy wrap
      add(2,  1, 0, 0, 0, 1, 0, 0,   11, 0,  0, 0, 0);
      add(11, 0, 0, 0, 1, 1, 0, 0,   11, 11, 1, 0, 0);
      add(1,  0, 0, 0, 1, 1, 0, 0,   11, 1,  0, 1, 0);
      // Down wrap and direction change
      add(1,  0, 0, 1, 0, 0, 0, 3,   5,  3,  0, 0, 0);
      add(1,  0, 0, 0, 1, 0, 0, 0,   5,  2,  0, 0, 0);
      add(1,  0, 0, 0, 1, 0, 0, 0,   5,  1,  0, 1, 0);
      add(1,  0, 0, 0, 1, 0, 0, 0,   5,  5,  1, 0, 0);
      add(1,  0, 0, 0, 1, 1, 0, 0,   5,  1,  0, 1, 0);
      // Saturate
      add(1,  0, 1, 0, 0, 1, 1, 0,   9,  0,  0, 0, 0);
      add(15, 0, 0, 0, 1, 1, 1, 0,   9,  9,  1, 0, 0);
      add(20, 0, 0, 0, 1, 0, 1, 0,   9,  1,  0, 1, 0);
      // One-shot up
      add(1,  0, 1, 0, 0, 1, 2, 0,   6,  0,  0, 0, 0);
      add(6,  0, 0, 0, 1, 1, 2, 0,   6,  6,  1, 0, 1);
      add(5,  0, 0, 0, 1, 1, 2, 0,   6,  6,  1, 0, 1);
      add(1,  0, 0, 1, 0, 1, 2, 2,   6,  2,  0, 0, 0);
      add(1,  0, 1, 0, 0, 1, 2, 0,   6,  0,  0, 0, 0);
      // Priority
      add(1,  0, 1, 1, 1, 1, 0, 7,   11, 0,  0, 0, 0);
      add(1,  0, 0, 1, 1, 1, 0, 7,   11, 7,  0, 0, 0);
      add(1,  0, 0, 1, 0, 1, 0, 3,   11, 3,  0, 0, 0);
      add(1,  0, 0, 0, 1, 1, 0, 0,   11, 4,  0, 0, 0);
      add(1,  1, 0, 0, 1, 1, 0, 0,   11, 0,  0, 0, 0);
      // rollover_val = 0 suppresses steps
      add(4,  0, 0, 0, 1, 1, 0, 0,   0,  0,  0, 0, 0);
      // Load above range then up-wrap
      add(1,  0, 0, 1, 0, 1, 0, 200, 10, 200, 0, 0, 0);
      add(1,  0, 0, 0, 1, 1, 0, 0,   10, 1,  0, 1, 0);
      // rollover_val = 1: both flags, up-wrap stays at 1
      add(1,  0, 0, 1, 0, 1, 0, 1,   1,  1,  1, 1, 0);
      add(1,  0, 0, 0, 1, 1, 0, 0,   1,  1,  1, 1, 0);
      // Down-wrap from 0; flags hold when rollover_val changes without a write
      add(1,  0, 1, 0, 0, 0, 0, 0,   5,  0,  0, 0, 0);
      add(1,  0, 0, 0, 1, 0, 0, 0,   5,  5,  1, 0, 0);
      add(1,  0, 0, 0, 0, 0, 0, 0,   7,  5,  1, 0, 0);
      // One-shot down; mode change while done does not exit
      add(1,  0, 0, 1, 0, 0, 2, 3,   6,  3,  0, 0, 0);
      add(2,  0, 0, 0, 1, 0, 2, 0,   6,  1,  0, 1, 1);
      add(1,  0, 0, 0, 1, 0, 2, 0,   6,  1,  0, 1, 1);
      add(3,  0, 0, 0, 1, 1, 0, 0,   6,  1,  0, 1, 1);
      // Saturate down from 0 gives 1
      add(1,  0, 1, 0, 0, 0, 1, 0,   5,  0,  0, 0, 0);
      add(1,  0, 0, 0, 1, 0, 1, 0,   5,  1,  0, 1, 0);

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            rst              = vecs[i].rst;
            ifc.clear        = vecs[i].clr;
            ifc.load         = vecs[i].ld;
            ifc.count_enable = vecs[i].en;
            ifc.dir          = vecs[i].dir;
            ifc.mode         = vecs[i].mode;
            ifc.load_val     = vecs[i].lv;
            ifc.rollover_val = vecs[i].rv;
            @(posedge tb_clk);
            #1;
         end
         check($sformatf("vec%0d", i), ifc.count_out, ifc.rollover_flag, ifc.bottom_flag,
               ifc.done, vecs[i].ecnt, vecs[i].eroll, vecs[i].ebot, vecs[i].edone);
      end

      // 4-bit instance: all-ones count up-wraps to 1 without overflow
      rst = 1'b1; ifc.count_enable = 0; ifc.load = 0; ifc.clear = 0;
      @(posedge tb_clk); #1;
      rst = 1'b0;
      check("w4_reset", {4'd0, ifc4.count_out}, ifc4.rollover_flag, ifc4.bottom_flag,
            ifc4.done, 8'd0, 0, 0, 0);
      ifc4.load = 1; ifc4.load_val = 4'd15; ifc4.rollover_val = 4'd15; ifc4.dir = 1;
      @(posedge tb_clk); #1;
      check("w4_load15", {4'd0, ifc4.count_out}, ifc4.rollover_flag, ifc4.bottom_flag,
            ifc4.done, 8'd15, 1, 0, 0);
      ifc4.load = 0; ifc4.count_enable = 1;
      @(posedge tb_clk); #1;
      check("w4_wrap", {4'd0, ifc4.count_out}, ifc4.rollover_flag, ifc4.bottom_flag,
            ifc4.done, 8'd1, 0, 1, 0);
      ifc4.count_enable = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/updown_flex_counter.md
Name: updown_flex_counter

Overview:
Parametrised successor to the team's flexible counter. Adds up/down counting, synchronous parallel load, and three terminal-count modes: wrap, saturate and one-shot. Provides registered terminal flags plus a one-shot done indicator. It is the general-purpose timing and sequencing counter for peripheral blocks such as baud dividers, timeout timers and beat counters.

Parameters:
NUM_BITS, 8, width of count_out, load_val and rollover_val (legal range 2..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous clear of count and flags; re-arms one-shot
count_enable  input  1  advance count by one step this cycle
dir  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of load_val
load_val  input  NUM_BITS  value written to count on load
rollover_val  input  NUM_BITS  terminal (top) value of the count range
mode  input  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap)
count_out  output  NUM_BITS  registered count
rollover_flag  output  1  registered; high while count_out == rollover_val
bottom_flag  output  1  registered; high while count_out == 1
done  output  1  registered; one-shot mode reached its terminal value

Behaviour:
- Reset is synchronous and active-high on port rst; single clock clk.
- Priority per rising edge: rst > clear > load > count_enable.
- rst = 1: count_out = 0, rollover_flag = 0, bottom_flag = 0, done = 0, FSM = RUN.
- clear = 1: identical to rst. Outputs are 0 after the edge.
- load = 1: count_out = load_val; flags computed from load_val; done = 0; FSM = RUN. Any value is accepted, including values above rollover_val.
- Count range is 1..rollover_val. Zero occurs only after rst/clear, or by loading 0.
- Up step:
  - wrap: count >= rollover_val gives 1; otherwise count + 1. This matches the legacy counter: 0,1,..,R,1,2,...
  - saturate: count >= rollover_val holds; otherwise count + 1.
- Down step:
  - wrap: count <= 1 gives rollover_val; otherwise count - 1. From 0 the next value is rollover_val.
  - saturate: count <= 1 holds, except from 0, which gives 1.
- One-shot FSM, 2 states:
  - RUN: steps as saturate. On the step that produces the terminal value (rollover_val for up, 1 for down), go to DONE and set done = 1 in the same edge as count_out.
  - DONE: count_enable is ignored and the count holds. Exit only by rst, clear or load.
- Changing mode while in DONE does not exit DONE.
- Flags are computed from the next count and the current rollover_val, and are updated only on edges where count_out is written (rst, clear, load, step). Otherwise they hold, even if rollover_val changes.
- Flag latency: zero cycles relative to count_out.
- rollover_val = 0: steps are suppressed (count holds). Load and clear still act.
- rollover_val = 1: up-wrap stays at 1; rollover_flag and bottom_flag are both high.
- No arithmetic overflow is possible: 2^NUM_BITS - 1 up-wraps to 1 via the >= compare.
- A dir change takes effect on the same edge it is sampled.
- All outputs are glitch-free register outputs; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/legacy wrap: hold rst 2 cycles; then rst = 0, mode = 0, dir = 1, R = 11, enable for 11 cycles -> count_out = 11, rollover_flag = 1; one more cycle -> count_out = 1, rollover_flag = 0, bottom_flag = 1.
- Down wrap + dir change: load 3, R = 5, dir = 0, enable 3 cycles -> 2, 1 (bottom_flag = 1), 5 (rollover_flag = 1); set dir = 1, 1 cycle -> 1.
- Saturate: mode = 1, R = 9, dir = 1, enable 15 cycles from clear -> count_out = 9, rollover_flag = 1 held; dir = 0, 20 cycles -> count_out = 1, bottom_flag = 1 held.
- One-shot: mode = 2, R = 6, enable 6 cycles -> count_out = 6, done = 1; 5 more enabled cycles -> still 6/1; load 2 -> count_out = 2, done = 0; clear -> count_out = 0, done = 0.
- Priority: assert clear, load (load_val = 7) and count_enable together -> count_out = 0; load with enable -> count_out = 7 (no step); rst mid-count at 4 -> count_out = 0 next edge.
- Boundaries: R = 0 with enable 4 cycles -> count_out holds at 0; load 200, R = 10, up-wrap -> 1; NUM_BITS = 4, load 15, R = 15, up -> 1 with rollover_flag 1 -> 0.
